// File: rtl/pcie_rst_ack_pkg.sv
// Shared types and default parameters for the PCIe reset-acknowledge responder.
package pcie_rst_ack_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        HOLD    = 3'd2,
        ACK     = 3'd3,
        RELEASE = 3'd4
    } state_t;

    typedef enum logic {
        WARM = 1'b0,
        COLD = 1'b1
    } rst_kind_t;

    localparam int DEF_CNT_W           = 8;
    localparam int DEF_DRAIN_TIMEOUT   = 4096;
    localparam int DEF_RST_HOLD_CYCLES = 32;

endpackage

// File: rtl/pcie_rst_ack_responder_if.sv
// Reset request/acknowledge bundle between the system reset controller and the
// PCIe subsystem responder, plus the NP traffic taps and core status.
interface pcie_rst_ack_responder_if #(
    parameter int CNT_W = 8
);
    import pcie_rst_ack_pkg::*;

    // Handshake: a request is held low until its ack goes low; the ack stays low
    // while the request is low and returns high only after release and core_ready.
    logic             cold_rst_n;
    logic             warm_rst_n;
    logic             np_req_sent;
    logic             np_cpl_rcvd;
    logic             core_ready;
    logic             cold_rst_ack_n;
    logic             warm_rst_ack_n;
    logic             core_rst;
    logic             tx_block;
    logic             drain_timeout;
    logic [CNT_W-1:0] outstanding;
    state_t           dbg_state;

    modport master (
        output cold_rst_n, warm_rst_n, np_req_sent, np_cpl_rcvd, core_ready,
        input  cold_rst_ack_n, warm_rst_ack_n, core_rst, tx_block,
        input  drain_timeout, outstanding, dbg_state
    );

    modport slave (
        input  cold_rst_n, warm_rst_n, np_req_sent, np_cpl_rcvd, core_ready,
        output cold_rst_ack_n, warm_rst_ack_n, core_rst, tx_block,
        output drain_timeout, outstanding, dbg_state
    );

endinterface

// File: rtl/pcie_np_outstanding_cnt.sv
// Saturating up/down count of outstanding non-posted requests, with force-clear.
module pcie_np_outstanding_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // A simultaneous request and completion cancel out.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != MAX_CNT)) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pcie_rst_ack_responder.sv
// Cold/warm reset responder: blocks new NP traffic, drains completions, holds the
// PCIe core in reset and returns active-low acks until the core is ready again.
module pcie_rst_ack_responder
    import pcie_rst_ack_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    pcie_rst_ack_responder_if.slave  bus
);

    localparam int DT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int HT_W = $clog2(RST_HOLD_CYCLES + 1);

    state_t           r_state;
    rst_kind_t        r_kind;
    logic [DT_W-1:0]  r_drain_cnt;
    logic [HT_W-1:0]  r_hold_cnt;
    logic             r_cold_ack_n;
    logic             r_warm_ack_n;
    logic             r_core_rst;
    logic             r_tx_block;
    logic             r_drain_to;

    logic             w_cold_req;
    logic             w_warm_req;
    logic             w_any_req;
    logic             w_drain_expired;
    logic             w_cnt_clr;
    rst_kind_t        w_kind_upd;
    logic [CNT_W-1:0] w_count;

    assign w_cold_req      = !bus.cold_rst_n;
    assign w_warm_req      = !bus.warm_rst_n;
    assign w_any_req       = w_cold_req || w_warm_req;
    assign w_drain_expired = (r_drain_cnt == DT_W'(DRAIN_TIMEOUT - 1));
    assign w_cnt_clr       = (r_state == DRAIN) && (w_count != '0) && w_drain_expired;
    // A cold request seen before ACK upgrades a warm sequence.
    assign w_kind_upd      = w_cold_req ? COLD : r_kind;

    pcie_np_outstanding_cnt #(
        .CNT_W (CNT_W)
    ) u_np_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (bus.np_req_sent),
        .i_dec   (bus.np_cpl_rcvd),
        .i_clr   (w_cnt_clr),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_kind       <= WARM;
            r_drain_cnt  <= '0;
            r_hold_cnt   <= '0;
            r_cold_ack_n <= 1'b1;
            r_warm_ack_n <= 1'b1;
            r_core_rst   <= 1'b0;
            r_tx_block   <= 1'b0;
            r_drain_to   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state     <= DRAIN;
                        r_kind      <= w_cold_req ? COLD : WARM;
                        r_tx_block  <= 1'b1;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    r_kind <= w_kind_upd;
                    if (w_count == '0) begin
                        r_state    <= HOLD;
                        r_core_rst <= 1'b1;
                        r_hold_cnt <= '0;
                    end else if (w_drain_expired) begin
                        r_state    <= HOLD;
                        r_core_rst <= 1'b1;
                        r_hold_cnt <= '0;
                        r_drain_to <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    r_kind <= w_kind_upd;
                    if (r_hold_cnt == HT_W'(RST_HOLD_CYCLES - 1)) begin
                        r_state      <= ACK;
                        r_cold_ack_n <= !(w_kind_upd == COLD);
                        r_warm_ack_n <= !((w_kind_upd == WARM) || w_warm_req);
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ACK: begin
                    // Acks are sticky here so they never drop under a held request.
                    if ((r_kind == COLD) && w_warm_req) begin
                        r_warm_ack_n <= 1'b0;
                    end
                    if (!w_any_req) begin
                        r_state    <= RELEASE;
                        r_core_rst <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (w_any_req) begin
                        r_state      <= DRAIN;
                        r_kind       <= w_cold_req ? COLD : WARM;
                        r_drain_cnt  <= '0;
                        r_cold_ack_n <= 1'b1;
                        r_warm_ack_n <= 1'b1;
                    end else if (bus.core_ready) begin
                        r_state      <= IDLE;
                        r_cold_ack_n <= 1'b1;
                        r_warm_ack_n <= 1'b1;
                        r_tx_block   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cold_rst_ack_n = r_cold_ack_n;
    assign bus.warm_rst_ack_n = r_warm_ack_n;
    assign bus.core_rst       = r_core_rst;
    assign bus.tx_block       = r_tx_block;
    assign bus.drain_timeout  = r_drain_to;
    assign bus.outstanding    = w_count;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_pcie_rst_ack_responder.sv
// Directed, table-driven bench for pcie_rst_ack_responder (CNT_W=4, timeout 16, hold 4).
module tb_pcie_rst_ack_responder;
    import pcie_rst_ack_pkg::*;

    typedef struct {
        logic       c;
        logic       w;
        logic       rq;
        logic       cp;
        logic       rd;
        logic       rs;
        logic       e_cack;
        logic       e_wack;
        logic       e_core;
        logic       e_tx;
        logic       e_dto;
        logic [3:0] e_out;
        state_t     e_st;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    pcie_rst_ack_responder_if #(.CNT_W(4)) bus ();

    pcie_rst_ack_responder #(
        .CNT_W           (4),
        .DRAIN_TIMEOUT   (16),
        .RST_HOLD_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic c, input logic w, input logic rq,
                                input logic cp, input logic rd, input logic rs,
                                input logic eca, input logic ewa, input logic ecr,
                                input logic etx, input logic edt, input int eo,
                                input state_t es);
        vec_t v;
        v.c = c; v.w = w; v.rq = rq; v.cp = cp; v.rd = rd; v.rs = rs;
        v.e_cack = eca; v.e_wack = ewa; v.e_core = ecr; v.e_tx = etx;
        v.e_dto = edt; v.e_out = 4'(eo); v.e_st = es;
        return v;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s %s: got %0d, expected %0d", tag, what, act, exp);
    endtask

    task automatic apply(input vec_t v, input string tag);
        bus.cold_rst_n  = v.c;
        bus.warm_rst_n  = v.w;
        bus.np_req_sent = v.rq;
        bus.np_cpl_rcvd = v.cp;
        bus.core_ready  = v.rd;
        reset           = v.rs;
        @(posedge clk);
        #1;
        chk(tag, "state",          32'(bus.dbg_state),    32'(v.e_st));
        chk(tag, "cold_rst_ack_n", 32'(bus.cold_rst_ack_n), 32'(v.e_cack));
        chk(tag, "warm_rst_ack_n", 32'(bus.warm_rst_ack_n), 32'(v.e_wack));
        chk(tag, "core_rst",       32'(bus.core_rst),     32'(v.e_core));
        chk(tag, "tx_block",       32'(bus.tx_block),     32'(v.e_tx));
        chk(tag, "drain_timeout",  32'(bus.drain_timeout), 32'(v.e_dto));
        chk(tag, "outstanding",    32'(bus.outstanding),  32'(v.e_out));
    endtask

    initial begin
        bus.cold_rst_n  = 1'b1;
        bus.warm_rst_n  = 1'b1;
        bus.np_req_sent = 1'b0;
        bus.np_cpl_rcvd = 1'b0;
        bus.core_ready  = 1'b0;

        // Reset values
        repeat (2) tbl.push_back(mk(1,1,0,0,0,1, 1,1,0,0,0,0,IDLE));
        tbl.push_back(mk(1,1,0,0,0,0, 1,1,0,0,0,0,IDLE));

        // Warm request, idle link
        tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,1,0,0,DRAIN));
        repeat (4) tbl.push_back(mk(1,0,0,0,0,0, 1,1,1,1,0,0,HOLD));
        repeat (2) tbl.push_back(mk(1,0,0,0,0,0, 1,0,1,1,0,0,ACK));
        repeat (2) tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,1,0,0,RELEASE));
        tbl.push_back(mk(1,1,0,0,1,0, 1,1,0,0,0,0,IDLE));
        tbl.push_back(mk(1,1,0,0,0,0, 1,1,0,0,0,0,IDLE));

        // Counter: inc, both together, dec, dec at zero
        tbl.push_back(mk(1,1,1,0,0,0, 1,1,0,0,0,1,IDLE));
        tbl.push_back(mk(1,1,1,0,0,0, 1,1,0,0,0,2,IDLE));
        tbl.push_back(mk(1,1,1,1,0,0, 1,1,0,0,0,2,IDLE));
        tbl.push_back(mk(1,1,0,1,0,0, 1,1,0,0,0,1,IDLE));
        tbl.push_back(mk(1,1,0,1,0,0, 1,1,0,0,0,0,IDLE));
        tbl.push_back(mk(1,1,0,1,0,0, 1,1,0,0,0,0,IDLE));
        tbl.push_back(mk(1,1,1,1,0,0, 1,1,0,0,0,0,IDLE));

        // Drain of 3 outstanding, cold request, late warm request in ACK
        for (int k = 1; k <= 3; k++) tbl.push_back(mk(1,1,1,0,0,0, 1,1,0,0,0,k,IDLE));
        repeat (5) tbl.push_back(mk(0,1,0,0,0,0, 1,1,0,1,0,3,DRAIN));
        tbl.push_back(mk(0,1,0,1,0,0, 1,1,0,1,0,2,DRAIN));
        tbl.push_back(mk(0,1,0,1,0,0, 1,1,0,1,0,1,DRAIN));
        tbl.push_back(mk(0,1,0,1,0,0, 1,1,0,1,0,0,DRAIN));
        repeat (4) tbl.push_back(mk(0,1,0,0,0,0, 1,1,1,1,0,0,HOLD));
        repeat (2) tbl.push_back(mk(0,1,0,0,0,0, 0,1,1,1,0,0,ACK));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,1,0,0,ACK));
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,1,1,0,0,ACK));
        tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,1,0,0,RELEASE));
        tbl.push_back(mk(1,1,0,0,1,0, 1,1,0,0,0,0,IDLE));

        // Both requests fall together
        tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,1,0,0,DRAIN));
        repeat (4) tbl.push_back(mk(0,0,0,0,0,0, 1,1,1,1,0,0,HOLD));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,1,0,0,ACK));
        tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,1,0,0,RELEASE));
        tbl.push_back(mk(1,1,0,0,1,0, 1,1,0,0,0,0,IDLE));

        // Warm first, cold upgrade while draining
        tbl.push_back(mk(1,1,1,0,0,0, 1,1,0,0,0,1,IDLE));
        tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,1,0,1,DRAIN));
        tbl.push_back(mk(0,0,0,1,0,0, 1,1,0,1,0,0,DRAIN));
        repeat (4) tbl.push_back(mk(0,0,0,0,0,0, 1,1,1,1,0,0,HOLD));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,1,0,0,ACK));
        tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,1,0,0,RELEASE));
        tbl.push_back(mk(1,1,0,0,1,0, 1,1,0,0,0,0,IDLE));

        // New warm request while in RELEASE
        tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,1,0,0,DRAIN));
        repeat (4) tbl.push_back(mk(1,0,0,0,0,0, 1,1,1,1,0,0,HOLD));
        tbl.push_back(mk(1,0,0,0,0,0, 1,0,1,1,0,0,ACK));
        tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,1,0,0,RELEASE));
        tbl.push_back(mk(1,0,0,0,0,0, 1,1,0,1,0,0,DRAIN));
        repeat (4) tbl.push_back(mk(1,0,0,0,0,0, 1,1,1,1,0,0,HOLD));
        tbl.push_back(mk(1,0,0,0,0,0, 1,0,1,1,0,0,ACK));
        tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,1,0,0,RELEASE));
        tbl.push_back(mk(1,1,0,0,1,0, 1,1,0,0,0,0,IDLE));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Saturation at 15, then drain back to zero
        for (int k = 1; k <= 16; k++)
            apply(mk(1,1,1,0,0,0, 1,1,0,0,0,(k > 15) ? 15 : k,IDLE), $sformatf("sat_inc%0d", k));
        for (int k = 14; k >= 0; k--)
            apply(mk(1,1,0,1,0,0, 1,1,0,0,0,k,IDLE), $sformatf("sat_dec%0d", k));

        // Drain timeout with 2 outstanding and no completions
        apply(mk(1,1,1,0,0,0, 1,1,0,0,0,1,IDLE), "to_req1");
        apply(mk(1,1,1,0,0,0, 1,1,0,0,0,2,IDLE), "to_req2");
        for (int k = 0; k < 16; k++)
            apply(mk(0,1,0,0,0,0, 1,1,0,1,0,2,DRAIN), $sformatf("to_drain%0d", k));
        for (int k = 0; k < 4; k++)
            apply(mk(0,1,0,0,0,0, 1,1,1,1,1,0,HOLD), $sformatf("to_hold%0d", k));
        apply(mk(0,1,0,0,0,0, 0,1,1,1,1,0,ACK), "to_ack");
        apply(mk(1,1,0,0,0,0, 0,1,0,1,1,0,RELEASE), "to_rel");
        apply(mk(1,1,0,0,1,0, 1,1,0,0,1,0,IDLE), "to_idle");

        // Reset pulse mid-HOLD with warm request still low
        apply(mk(1,0,0,0,0,0, 1,1,0,1,1,0,DRAIN), "rh_drain");
        apply(mk(1,0,0,0,0,0, 1,1,1,1,1,0,HOLD), "rh_hold0");
        apply(mk(1,0,0,0,0,0, 1,1,1,1,1,0,HOLD), "rh_hold1");
        apply(mk(1,0,0,0,0,1, 1,1,0,0,0,0,IDLE), "rh_reset");
        apply(mk(1,0,0,0,0,0, 1,1,0,1,0,0,DRAIN), "rh_redrain");
        for (int k = 0; k < 4; k++)
            apply(mk(1,0,0,0,0,0, 1,1,1,1,0,0,HOLD), $sformatf("rh_rehold%0d", k));
        apply(mk(1,0,0,0,0,0, 1,0,1,1,0,0,ACK), "rh_ack");
        apply(mk(1,1,0,0,0,0, 1,0,0,1,0,0,RELEASE), "rh_rel");
        apply(mk(1,1,0,0,1,0, 1,1,0,0,0,0,IDLE), "rh_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
